// File: rtl/amos_fifo_pkg.sv
// ============================================================================
// amos_fifo_pkg : shared lane limits and count-width helper for the FIFO.
// Revision 1.0
// ============================================================================
`default_nettype none

package amos_fifo_pkg;

   localparam int MAX_PUSH_LANES = 4;
   localparam int MAX_POP_LANES  = 4;

   // Width able to hold every value 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/amos_ptr_wrap.sv
// ============================================================================
// amos_ptr_wrap : modular pointer adder, sum_o = (ptr_i + inc_i) mod DEPTH.
// Revision 1.0
// ============================================================================
`default_nettype none

module amos_ptr_wrap
   import amos_fifo_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int INC_W  = cnt_w(DEPTH),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic [PTR_W-1:0] ptr_i,
   input  logic [INC_W-1:0] inc_i,
   output logic [PTR_W-1:0] sum_o
);

   localparam int SUM_W = PTR_W + 1;

   logic [SUM_W-1:0] w_sum;

   // inc_i never exceeds DEPTH, so one conditional subtract completes the modulo.
   assign w_sum = SUM_W'(ptr_i) + SUM_W'(inc_i);
   assign sum_o = (w_sum >= SUM_W'(DEPTH)) ? PTR_W'(w_sum - SUM_W'(DEPTH))
                                           : PTR_W'(w_sum);

endmodule

`default_nettype wire

// File: rtl/amos_multiport_fifo.sv
// ============================================================================
// amos_multiport_fifo : multi-lane push/pop FIFO, any DEPTH, no fall-through.
// Optional sticky protocol error: define AMOS_MPFIFO_ERR_STICKY_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module amos_multiport_fifo
   import amos_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 16,
   parameter int NUM_PUSH   = 2,
   parameter int NUM_POP    = 2,
   localparam int CNT_W     = cnt_w(DEPTH),
   localparam int PUSH_W    = $clog2(NUM_PUSH + 1),
   localparam int POP_W     = $clog2(NUM_POP + 1)
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic                               flush_i,
   input  logic [PUSH_W-1:0]                  push_cnt_i,
   input  logic [NUM_PUSH-1:0][DATA_WIDTH-1:0] data_i,
   input  logic [POP_W-1:0]                   pop_cnt_i,
   output logic [NUM_POP-1:0][DATA_WIDTH-1:0]  data_o,
   output logic [NUM_POP-1:0]                 valid_o,
   output logic [CNT_W-1:0]                   used_cnt_o,
   output logic [CNT_W-1:0]                   free_cnt_o,
   output logic                               full_o,
   output logic                               empty_o,
   output logic                               err_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [CNT_W-1:0]      r_count;

   logic [PTR_W-1:0]      w_rd_ptr_nxt;
   logic [PTR_W-1:0]      w_wr_ptr_nxt;
   logic [CNT_W-1:0]      w_free;
   logic [CNT_W-1:0]      w_push_req;
   logic [CNT_W-1:0]      w_pop_req;
   logic [CNT_W-1:0]      w_push_n;
   logic [CNT_W-1:0]      w_pop_n;
   logic                  w_push_ok;
   logic                  w_pop_ok;
   logic [PTR_W-1:0]      w_waddr [NUM_PUSH];
   logic [PTR_W-1:0]      w_raddr [NUM_POP];

   // Acceptance looks only at registered occupancy; a same-cycle pop never frees room.
   assign w_free     = CNT_W'(DEPTH) - r_count;
   assign w_push_req = CNT_W'(push_cnt_i);
   assign w_pop_req  = CNT_W'(pop_cnt_i);
   assign w_push_ok  = (w_push_req <= w_free);
   assign w_pop_ok   = (w_pop_req <= r_count);
   assign w_push_n   = (w_push_ok && !flush_i) ? w_push_req : '0;
   assign w_pop_n    = (w_pop_ok && !flush_i) ? w_pop_req : '0;

   amos_ptr_wrap #(.DEPTH(DEPTH), .INC_W(CNT_W)) u_wr_ptr_wrap (
      .ptr_i (r_wr_ptr),
      .inc_i (w_push_n),
      .sum_o (w_wr_ptr_nxt)
   );

   amos_ptr_wrap #(.DEPTH(DEPTH), .INC_W(CNT_W)) u_rd_ptr_wrap (
      .ptr_i (r_rd_ptr),
      .inc_i (w_pop_n),
      .sum_o (w_rd_ptr_nxt)
   );

   generate
      for (genvar k = 0; k < NUM_PUSH; k++) begin : g_wr_lane
         amos_ptr_wrap #(.DEPTH(DEPTH), .INC_W(CNT_W)) u_waddr (
            .ptr_i (r_wr_ptr),
            .inc_i (CNT_W'(k)),
            .sum_o (w_waddr[k])
         );
      end

      for (genvar k = 0; k < NUM_POP; k++) begin : g_rd_lane
         amos_ptr_wrap #(.DEPTH(DEPTH), .INC_W(CNT_W)) u_raddr (
            .ptr_i (r_rd_ptr),
            .inc_i (CNT_W'(k)),
            .sum_o (w_raddr[k])
         );
         assign data_o[k]  = r_mem[w_raddr[k]];
         assign valid_o[k] = (r_count > CNT_W'(k));
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (flush_i) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_rd_ptr <= w_rd_ptr_nxt;
         r_wr_ptr <= w_wr_ptr_nxt;
         r_count  <= r_count + w_push_n - w_pop_n;
      end
   end

   // Storage is touched only when a push is accepted, giving a clean write enable.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int e = 0; e < DEPTH; e++) begin
            r_mem[e] <= '0;
         end
      end else if (w_push_n != '0) begin
         for (int e = 0; e < DEPTH; e++) begin
            for (int k = 0; k < NUM_PUSH; k++) begin
               if ((CNT_W'(k) < w_push_n) && (w_waddr[k] == PTR_W'(e))) begin
                  r_mem[e] <= data_i[k];
               end
            end
         end
      end
   end

   assign used_cnt_o = r_count;
   assign free_cnt_o = w_free;
   assign full_o     = (r_count == CNT_W'(DEPTH));
   assign empty_o    = (r_count == '0);

`ifdef AMOS_MPFIFO_ERR_STICKY_EN
   logic r_err;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_err <= 1'b0;
      end else if (flush_i) begin
         r_err <= 1'b0;
      end else if (!w_push_ok || !w_pop_ok) begin
         r_err <= 1'b1;
      end
   end

   assign err_o = r_err;
`else
   assign err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_amos_multiport_fifo.sv
// ============================================================================
// tb_amos_multiport_fifo : directed bench for DEPTH=16 and DEPTH=5 instances.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_amos_multiport_fifo;

`ifdef AMOS_MPFIFO_ERR_STICKY_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- DUT A: DEPTH 16 ----------------
   logic             rst_a_n;
   logic             flush_a;
   logic [1:0]       push_a;
   logic [1:0][15:0] data_a;
   logic [1:0]       pop_a;
   logic [1:0][15:0] dout_a;
   logic [1:0]       valid_a;
   logic [4:0]       used_a;
   logic [4:0]       free_a;
   logic             full_a;
   logic             empty_a;
   logic             err_a;

   amos_multiport_fifo #(
      .DATA_WIDTH (16),
      .DEPTH      (16),
      .NUM_PUSH   (2),
      .NUM_POP    (2)
   ) dut_a (
      .clk_i      (clk),
      .rst_ni     (rst_a_n),
      .flush_i    (flush_a),
      .push_cnt_i (push_a),
      .data_i     (data_a),
      .pop_cnt_i  (pop_a),
      .data_o     (dout_a),
      .valid_o    (valid_a),
      .used_cnt_o (used_a),
      .free_cnt_o (free_a),
      .full_o     (full_a),
      .empty_o    (empty_a),
      .err_o      (err_a)
   );

   // ---------------- DUT B: DEPTH 5 ----------------
   logic             rst_b_n;
   logic             flush_b;
   logic [1:0]       push_b;
   logic [1:0][15:0] data_b;
   logic [1:0]       pop_b;
   logic [1:0][15:0] dout_b;
   logic [1:0]       valid_b;
   logic [2:0]       used_b;
   logic [2:0]       free_b;
   logic             full_b;
   logic             empty_b;
   logic             err_b;

   amos_multiport_fifo #(
      .DATA_WIDTH (16),
      .DEPTH      (5),
      .NUM_PUSH   (2),
      .NUM_POP    (2)
   ) dut_b (
      .clk_i      (clk),
      .rst_ni     (rst_b_n),
      .flush_i    (flush_b),
      .push_cnt_i (push_b),
      .data_i     (data_b),
      .pop_cnt_i  (pop_b),
      .data_o     (dout_b),
      .valid_o    (valid_b),
      .used_cnt_o (used_b),
      .free_cnt_o (free_b),
      .full_o     (full_b),
      .empty_o    (empty_b),
      .err_o      (err_b)
   );

   typedef struct {
      logic        flush;
      logic [1:0]  push;
      logic [15:0] d0;
      logic [15:0] d1;
      logic [1:0]  pop;
      int          used;
      logic [15:0] e0;
      logic [15:0] e1;
      logic        err;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [1:0] exp_valid(input int used);
      return (used >= 2) ? 2'b11 : (used == 1) ? 2'b01 : 2'b00;
   endfunction

   task automatic step_a(input logic fl, input logic [1:0] pu, input logic [15:0] d0,
                         input logic [15:0] d1, input logic [1:0] po);
      @(negedge clk);
      flush_a   = fl;
      push_a    = pu;
      data_a[0] = d0;
      data_a[1] = d1;
      pop_a     = po;
      @(posedge clk);
      #1;
   endtask

   task automatic step_b(input logic [1:0] pu, input logic [15:0] d0,
                         input logic [15:0] d1, input logic [1:0] po);
      @(negedge clk);
      flush_b   = 1'b0;
      push_b    = pu;
      data_b[0] = d0;
      data_b[1] = d1;
      pop_b     = po;
      @(posedge clk);
      #1;
   endtask

   task automatic check_a(input string tag, input int used, input logic [15:0] e0,
                          input logic [15:0] e1, input logic err);
      chk({tag, ".used"},  64'(used_a),  64'(used));
      chk({tag, ".free"},  64'(free_a),  64'(16 - used));
      chk({tag, ".full"},  64'(full_a),  64'(used == 16));
      chk({tag, ".empty"}, 64'(empty_a), 64'(used == 0));
      chk({tag, ".valid"}, 64'(valid_a), 64'(exp_valid(used)));
      chk({tag, ".d0"},    64'(dout_a[0]), 64'(e0));
      chk({tag, ".d1"},    64'(dout_a[1]), 64'(e1));
      chk({tag, ".err"},   64'(err_a),   64'(err & ERR_EN));
   endtask

   task automatic check_b(input string tag, input int used, input logic [15:0] e0,
                          input logic [15:0] e1);
      chk({tag, ".used"},  64'(used_b),  64'(used));
      chk({tag, ".free"},  64'(free_b),  64'(5 - used));
      chk({tag, ".full"},  64'(full_b),  64'(used == 5));
      chk({tag, ".empty"}, 64'(empty_b), 64'(used == 0));
      chk({tag, ".valid"}, 64'(valid_b), 64'(exp_valid(used)));
      chk({tag, ".d0"},    64'(dout_b[0]), 64'(e0));
      chk({tag, ".d1"},    64'(dout_b[1]), 64'(e1));
      chk({tag, ".err"},   64'(err_b),   64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // flush push d0 d1 pop | used e0 e1 err
      tbl[0] = '{1'b0, 2'd2, 16'h00A1, 16'h00B2, 2'd0, 2, 16'h00A1, 16'h00B2, 1'b0};
      tbl[1] = '{1'b0, 2'd0, 16'h0000, 16'h0000, 2'd1, 1, 16'h00B2, 16'h0000, 1'b0};
      tbl[2] = '{1'b0, 2'd2, 16'h00C3, 16'h00D4, 2'd1, 2, 16'h00C3, 16'h00D4, 1'b0};
      tbl[3] = '{1'b0, 2'd0, 16'h0000, 16'h0000, 2'd3, 2, 16'h00C3, 16'h00D4, 1'b1};
      tbl[4] = '{1'b0, 2'd0, 16'h0000, 16'h0000, 2'd2, 0, 16'h0000, 16'h0000, 1'b1};
      tbl[5] = '{1'b0, 2'd0, 16'h0000, 16'h0000, 2'd1, 0, 16'h0000, 16'h0000, 1'b1};
      tbl[6] = '{1'b1, 2'd0, 16'h0000, 16'h0000, 2'd0, 0, 16'h00A1, 16'h00B2, 1'b0};

      rst_a_n = 1'b0; rst_b_n = 1'b0;
      flush_a = 1'b0; push_a = '0; data_a = '0; pop_a = '0;
      flush_b = 1'b0; push_b = '0; data_b = '0; pop_b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_a_n = 1'b1; rst_b_n = 1'b1;
      #1;
      check_a("rst_a", 0, 16'h0000, 16'h0000, 1'b0);
      check_b("rst_b", 0, 16'h0000, 16'h0000);

      // ---- table: basic push/pop, simultaneous, rejections, flush ----
      for (int i = 0; i < 7; i++) begin
         step_a(tbl[i].flush, tbl[i].push, tbl[i].d0, tbl[i].d1, tbl[i].pop);
         check_a($sformatf("vec%0d", i), tbl[i].used, tbl[i].e0, tbl[i].e1, tbl[i].err);
      end

      // ---- fill DEPTH 16 to 15, reject overflow, then fill to full ----
      for (int i = 0; i < 7; i++) begin
         step_a(1'b0, 2'd2, 16'(16'h0100 + 2 * i), 16'(16'h0101 + 2 * i), 2'd0);
         check_a($sformatf("fill%0d", i), 2 * (i + 1), 16'h0100, 16'h0101, 1'b0);
      end
      step_a(1'b0, 2'd1, 16'h010E, 16'h0000, 2'd0);
      check_a("used15", 15, 16'h0100, 16'h0101, 1'b0);
      step_a(1'b0, 2'd2, 16'hDEAD, 16'hBEEF, 2'd0);
      check_a("push_reject", 15, 16'h0100, 16'h0101, 1'b1);
      step_a(1'b0, 2'd1, 16'h010F, 16'h0000, 2'd0);
      check_a("full16", 16, 16'h0100, 16'h0101, 1'b1);
      // full: push rejected on registered state even though a pop is accepted
      step_a(1'b0, 2'd2, 16'hDEAD, 16'hBEEF, 2'd2);
      check_a("full_push_pop", 14, 16'h0102, 16'h0103, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step_a(1'b0, 2'd0, 16'h0000, 16'h0000, 2'd2);
      end
      check_a("used8", 8, 16'h0108, 16'h0109, 1'b1);
      step_a(1'b1, 2'd2, 16'hDEAD, 16'hBEEF, 2'd0);
      check_a("flush_push", 0, 16'h0100, 16'h0101, 1'b0);

      // ---- DEPTH 5: wrap of pointers and lanes ----
      @(negedge clk);
      push_b = 2'd2; data_b[0] = 16'hE000; data_b[1] = 16'hE001; pop_b = 2'd0;
      #1;
      chk("no_fallthrough.d0", 64'(dout_b[0]), 64'(16'h0000));
      chk("no_fallthrough.used", 64'(used_b), 64'(0));
      @(posedge clk);
      #1;
      check_b("b1", 2, 16'hE000, 16'hE001);
      step_b(2'd1, 16'hE002, 16'h0000, 2'd0);
      check_b("b2", 3, 16'hE000, 16'hE001);
      step_b(2'd2, 16'hE003, 16'hE004, 2'd0);
      check_b("b3", 5, 16'hE000, 16'hE001);
      step_b(2'd0, 16'h0000, 16'h0000, 2'd2);
      check_b("b4", 3, 16'hE002, 16'hE003);
      step_b(2'd2, 16'hE005, 16'hE006, 2'd0);
      check_b("b5", 5, 16'hE002, 16'hE003);
      step_b(2'd0, 16'h0000, 16'h0000, 2'd2);
      check_b("b6", 3, 16'hE004, 16'hE005);
      step_b(2'd0, 16'h0000, 16'h0000, 2'd1);
      check_b("b7", 2, 16'hE005, 16'hE006);
      step_b(2'd2, 16'hE007, 16'hE008, 2'd0);
      check_b("b8", 4, 16'hE005, 16'hE006);
      step_b(2'd0, 16'h0000, 16'h0000, 2'd1);
      check_b("b9", 3, 16'hE006, 16'hE007);
      step_b(2'd2, 16'hE009, 16'hE00A, 2'd0);
      check_b("b10", 5, 16'hE006, 16'hE007);
      step_b(2'd0, 16'h0000, 16'h0000, 2'd2);
      check_b("b11", 3, 16'hE008, 16'hE009);
      step_b(2'd0, 16'h0000, 16'h0000, 2'd2);
      check_b("b12", 1, 16'hE00A, 16'hE006);

      // ---- asynchronous reset mid-operation ----
      @(negedge clk);
      push_b = 2'd2; data_b[0] = 16'h1111; data_b[1] = 16'h2222; pop_b = 2'd0;
      #2;
      rst_b_n = 1'b0;
      #1;
      check_b("async_rst", 0, 16'h0000, 16'h0000);
      @(posedge clk);
      #1;
      check_b("rst_held", 0, 16'h0000, 16'h0000);
      @(negedge clk);
      push_b = '0;
      rst_b_n = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
